// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Bus bundle for the multi-digit seven-segment scan driver.
//               Carries the load/data/mode inputs and the display outputs.
//               master : the agent that loads words and selects modes
//               slave  : the scan driver itself
//   load        1         capture Data_in on the next rising clock edge
//   Data_in     4*DIGITS  nibble word, nibble 0 is the least significant
//   dec_mode    1         1 = decimal (nibbles 10..15 show a dash)
//   blank_lz    1         1 = blank leading zero digits
//   outDisplay  7         segments {g,f,e,d,c,b,a}, active-low
//   an          DIGITS    anode enables, active-low, one-hot-low
//   OUTbinario  4*DIGITS  currently held word
//   frame       1         one-cycle end-of-scan pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   Data_in;
    logic                  dec_mode;
    logic                  blank_lz;
    logic [6:0]            outDisplay;
    logic [DIGITS-1:0]     an;
    logic [4*DIGITS-1:0]   OUTbinario;
    logic                  frame;

    modport master (
        output load,
        output Data_in,
        output dec_mode,
        output blank_lz,
        input  outDisplay,
        input  an,
        input  OUTbinario,
        input  frame
    );

    modport slave (
        input  load,
        input  Data_in,
        input  dec_mode,
        input  blank_lz,
        output outDisplay,
        output an,
        output OUTbinario,
        output frame
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Parametrised time-multiplexed seven-segment driver. Latches a
//               DIGITS-wide nibble word on load and scans it onto one shared
//               active-low segment bus, one active-low anode per digit, with
//               hex/decimal modes, leading-zero blanking and a frame strobe.
//   clk  in  system clock, rising-edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of seg7_scan_driver_if (load, Data_in, dec_mode,
//        blank_lz in; outDisplay, an, OUTbinario, frame out)
// Parameters  : DIGITS      number of digits, 1..8
//               REFRESH_DIV cycles each digit stays lit, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_RCNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    logic [4*DIGITS-1:0] r_held;
    logic [c_CNT_W-1:0]  r_rcnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_frame;

    logic [3:0]          w_nib;
    logic                w_lead_zero;
    logic [DIGITS-1:0]   w_zero_from;
    logic                w_run_zero;
    logic [6:0]          w_hex_seg;
    logic [6:0]          w_seg;

    // ------------------------------------------------------------------
    // Held word, refresh divider, digit index and frame strobe.
    // Loading never touches the scan state, so a load mid-scan only
    // changes what the currently lit digit shows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held  <= '0;
            r_rcnt  <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            if (bus.load) begin
                r_held <= bus.Data_in;
            end

            r_frame <= 1'b0;
            if (r_rcnt == c_RCNT_LAST) begin
                r_rcnt <= '0;
                if (r_idx == c_IDX_LAST) begin
                    r_idx   <= '0;
                    r_frame <= 1'b1;
                end else begin
                    r_idx <= r_idx + c_IDX_W'(1);
                end
            end else begin
                r_rcnt <= r_rcnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // w_zero_from[k] is set when nibbles k..DIGITS-1 are all zero, built
    // from the top digit downwards. Dash nibbles are >= 10 and therefore
    // naturally count as nonzero.
    // ------------------------------------------------------------------
    always_comb begin
        w_run_zero  = 1'b1;
        w_zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_run_zero     = w_run_zero & (r_held[4*k +: 4] == 4'h0);
            w_zero_from[k] = w_run_zero;
        end
    end

    // Select the lit digit's nibble and its leading-zero flag with an
    // explicit compare per digit so non-power-of-two DIGITS stay in range.
    always_comb begin
        w_nib       = 4'h0;
        w_lead_zero = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_nib       = r_held[4*k +: 4];
                w_lead_zero = (k != 0) && w_zero_from[k];
            end
        end
    end

    always_comb begin
        w_hex_seg = c_SEG_BLANK;
        case (w_nib)
            4'h0:    w_hex_seg = 7'b1000000;
            4'h1:    w_hex_seg = 7'b1111001;
            4'h2:    w_hex_seg = 7'b0100100;
            4'h3:    w_hex_seg = 7'b0110000;
            4'h4:    w_hex_seg = 7'b0011001;
            4'h5:    w_hex_seg = 7'b0010010;
            4'h6:    w_hex_seg = 7'b0000010;
            4'h7:    w_hex_seg = 7'b1111000;
            4'h8:    w_hex_seg = 7'b0000000;
            4'h9:    w_hex_seg = 7'b0010000;
            4'hA:    w_hex_seg = 7'b0001000;
            4'hB:    w_hex_seg = 7'b0000011;
            4'hC:    w_hex_seg = 7'b1000110;
            4'hD:    w_hex_seg = 7'b0100001;
            4'hE:    w_hex_seg = 7'b0000110;
            4'hF:    w_hex_seg = 7'b0001110;
            default: w_hex_seg = c_SEG_BLANK;
        endcase
    end

    // Blanking wins over everything; decimal mode replaces letters by a dash.
    always_comb begin
        w_seg = w_hex_seg;
        if (bus.blank_lz && w_lead_zero) begin
            w_seg = c_SEG_BLANK;
        end else if (bus.dec_mode && (w_nib >= 4'd10)) begin
            w_seg = c_SEG_DASH;
        end
    end

    // The anode stays active for a blanked digit; only segments go dark.
    assign bus.an         = ~(DIGITS'(1) << r_idx);
    assign bus.outDisplay = w_seg;
    assign bus.OUTbinario = r_held;
    assign bus.frame      = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with DIGITS=4 and
//               REFRESH_DIV=4. A behavioural model predicts every output on
//               every cycle; predictions are queued when stimulus is applied
//               and popped against the DUT after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_DIGITS = 4;
    localparam int c_RDIV   = 4;
    localparam int c_FRAME  = c_DIGITS * c_RDIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(c_DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS      (c_DIGITS),
        .REFRESH_DIV (c_RDIV)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [15:0] bin;
        logic        frame;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_held   = '0;
    int          m_n      = 0;   // edges since the last reset edge
    int          n_frames;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Position within the scan is derived purely from elapsed cycles.
    function automatic exp_t model_out();
        exp_t        e;
        int          idx;
        logic [15:0] upper;
        logic [3:0]  nib;
        idx     = (m_n / c_RDIV) % c_DIGITS;
        upper   = m_held >> (4 * idx);
        nib     = upper[3:0];
        e.an    = ~(4'b0001 << idx);
        e.bin   = m_held;
        e.frame = (m_n != 0) && ((m_n % c_FRAME) == 0);
        if (bus.blank_lz && idx > 0 && upper == 16'h0)
            e.seg = 7'b1111111;
        else if (bus.dec_mode && nib >= 4'd10)
            e.seg = 7'b0111111;
        else
            e.seg = seg_code(nib);
        return e;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] d);
        exp_t e;
        rst         = r;
        bus.load    = ld;
        bus.Data_in = d;
        @(posedge clk);
        if (r) begin
            m_held = '0;
            m_n    = 0;
        end else begin
            if (ld) m_held = d;
            m_n++;
        end
        #1;
        sb_q.push_back(model_out());
        e = sb_q.pop_front();
        check("an",         bus.an,         e.an);
        check("outDisplay", bus.outDisplay, e.seg);
        check("OUTbinario", bus.OUTbinario, e.bin);
        check("frame",      bus.frame,      e.frame);
        if (bus.frame === 1'b1) n_frames++;
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.Data_in  = '0;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset, second cycle also tries to load (reset has priority)
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'hFFFF);
        check("rst_bin",   bus.OUTbinario, 16'h0000);
        check("rst_an",    bus.an,         4'b1110);
        check("rst_seg",   bus.outDisplay, 7'b1000000);
        check("rst_frame", bus.frame,      1'b0);

        // Hex scan of 0B10, two full frames
        n_frames = 0;
        step(1'b0, 1'b1, 16'h0B10);
        idle(31);
        check("hex_frames", n_frames, 2);

        // Leading-zero blanking on and off
        bus.blank_lz = 1'b1;
        step(1'b0, 1'b1, 16'h000B);
        idle(15);
        bus.blank_lz = 1'b0;
        idle(16);

        // Decimal mode with blanking
        bus.dec_mode = 1'b1;
        bus.blank_lz = 1'b1;
        step(1'b0, 1'b1, 16'h00B5);
        idle(16);

        // Load mid-scan on the second cycle of digit 2
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        for (int i = 0; i < c_FRAME && (m_n % c_FRAME) != 9; i++) idle(1);
        step(1'b0, 1'b1, 16'h0300);
        check("mid_seg", bus.outDisplay, 7'b0110000);
        check("mid_an",  bus.an,         4'b1011);
        idle(10);

        // Reset in the middle of a scan, then a full frame
        step(1'b1, 1'b0, 16'h0);
        check("midrst_an", bus.an, 4'b1110);
        n_frames = 0;
        idle(c_FRAME + 2);
        check("midrst_frames", n_frames, 1);

        // Random words and modes
        for (int i = 0; i < 6; i++) begin
            bus.dec_mode = 1'($urandom_range(1));
            bus.blank_lz = 1'($urandom_range(1));
            step(1'b0, 1'b1, 16'($urandom));
            idle(c_FRAME);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
